axis_rr_packet_arbiter: RTL and testbench
=========================================

// Module: axis_rr_packet_arbiter
// PURPOSE
//  Shares one AXIS sink between NUM_STREAMS AXIS sources, packet by packet, round-robin.
//  Counterpart of the broadcaster: merges streams (N:1) where the broadcaster fans out (1:N).
//  Grant is held from the first beat until the tlast beat is accepted; packets never interleave.
//  A per-source enable mask lets control logic exclude sources at packet boundaries.
// PARAMETERS
//  AXIS_BYTES   1  tdata width in bytes (tdata is AXIS_BYTES*8 bits)
//  NUM_STREAMS  2  number of source streams, >=2
// PORTS
//  clk            in   1                       clock, all logic on rising edge
//  sreset         in   1                       synchronous reset, active-high
//  enable_mask    in   NUM_STREAMS             bit i=1: source i may be granted
//  axis_i_tready  out  NUM_STREAMS             per-source ready
//  axis_i_tvalid  in   NUM_STREAMS             per-source valid
//  axis_i_tlast   in   NUM_STREAMS             per-source last
//  axis_i_tdata   in   NUM_STREAMS*AXIS_BYTES*8 source i in bits [i*AXIS_BYTES*8 +: AXIS_BYTES*8]
//  axis_o_tready  in   1                       sink ready
//  axis_o_tvalid  out  1                       sink valid
//  axis_o_tlast   out  1                       sink last
//  axis_o_tdata   out  AXIS_BYTES*8            sink data
//  grant_idx      out  max(1,$clog2(NUM_STREAMS)) index of source currently owning the sink
//  busy           out  1                       1 while a packet is in progress (LOCKED)
// BEHAVIOUR
//  States: IDLE, LOCKED. Registers: state, grant_idx, last_idx (previous winner).
//  Reset: state=IDLE, grant_idx=0, last_idx=NUM_STREAMS-1 (first search starts at source 0).
//   Outputs during and one cycle after reset: axis_i_tready=0, axis_o_tvalid=0, busy=0.
//  IDLE: all axis_i_tready=0; axis_o_tvalid=0; axis_o_tlast/tdata=0.
//   Request vector req = axis_i_tvalid & enable_mask.
//   If req!=0: winner = first set bit of req searching last_idx+1, last_idx+2, ... modulo
//   NUM_STREAMS (wraps from NUM_STREAMS-1 to 0). Next cycle: grant_idx=winner, state=LOCKED.
//   If req==0: stay IDLE.
//  LOCKED: combinational passthrough of source g=grant_idx:
//   axis_o_tvalid=axis_i_tvalid[g]; tlast/tdata from source g;
//   axis_i_tready[g]=axis_o_tready; all other tready=0. busy=1.
//   On beat accepted (axis_o_tvalid & axis_o_tready) with tlast=1: next cycle state=IDLE,
//   last_idx=g. Otherwise remain LOCKED (tvalid gaps in source g are passed through as-is).
//  Latency: 1 arbitration cycle from first request to sink tvalid; 0 cycles data path while
//   LOCKED; 1 bubble cycle (IDLE) between consecutive packets, including same-source ones.
//  enable_mask is sampled only in IDLE; clearing a bit mid-packet does not cut that packet.
//  Sources are AXIS-compliant (tvalid not withdrawn before acceptance); the arbiter does not
//   depend on it for grant selection, since grant is latched.
//  Single-beat packet (tvalid&tlast on first beat): LOCKED for exactly the cycles until accepted.
//  Sink stall (axis_o_tready=0): state held, no tready to any source, data stable.
//  Reset mid-packet: packet is abandoned; state=IDLE, last_idx=NUM_STREAMS-1 next cycle; no
//   partial-beat recovery. Upstream sources must also be reset.
//  No buffering: zero storage for tdata; arbitration state only.
// TESTING
//  1 Reset: assert sreset 3 cycles, all sources valid -> no tready, axis_o_tvalid=0 throughout
//    and on the first cycle after release.
//  2 Single source: src0 sends 4-beat packet 0x01..0x04, sink always ready -> sink sees
//    0x01..0x04, tlast on 0x04, grant_idx=0, first sink beat 1 cycle after src0 tvalid.
//  3 Round-robin fairness (N=3): all sources continuously offer 2-beat packets
//    -> grant order 0,1,2,0,1,2, one IDLE bubble between packets, no interleaved beats.
//  4 Backpressure: sink tready toggles 1010 mid-packet from src1 -> each beat appears exactly
//    once, src1 tready mirrors sink tready, src0 tready stays 0.
//  5 Mask: enable_mask=3'b101 with all valid -> only 0 and 2 granted; clear bit 0 during
//    src0 packet -> packet completes, next grant is 2.
//  6 Reset mid-packet: sreset after beat 2 of a 5-beat src1 packet -> next grant goes to
//    src0 if valid; no stale beats appear on the sink.

Source files
------------

// File: rtl/axis_rr_packet_arbiter_if.sv
// AXIS bundle for the N:1 packet arbiter: NUM_STREAMS source channels plus one sink channel.
interface axis_rr_packet_arbiter_if #(
    parameter int NUM_STREAMS = 2,
    parameter int AXIS_BYTES  = 1
);
    logic [NUM_STREAMS-1:0]              axis_i_tready;
    logic [NUM_STREAMS-1:0]              axis_i_tvalid;
    logic [NUM_STREAMS-1:0]              axis_i_tlast;
    logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata;
    logic                                axis_o_tready;
    logic                                axis_o_tvalid;
    logic                                axis_o_tlast;
    logic [AXIS_BYTES*8-1:0]             axis_o_tdata;

    // Arbiter side.
    modport slave (
        output axis_i_tready,
        input  axis_i_tvalid, axis_i_tlast, axis_i_tdata,
        input  axis_o_tready,
        output axis_o_tvalid, axis_o_tlast, axis_o_tdata
    );

    // Environment side: drives the sources, acts as the sink.
    modport master (
        input  axis_i_tready,
        output axis_i_tvalid, axis_i_tlast, axis_i_tdata,
        output axis_o_tready,
        input  axis_o_tvalid, axis_o_tlast, axis_o_tdata
    );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// N:1 AXIS packet arbiter: round-robin grant at packet boundaries, grant held until tlast
// is accepted, zero-storage combinational passthrough of the granted source.
module axis_rr_packet_arbiter #(
    parameter int  AXIS_BYTES  = 1,
    parameter int  NUM_STREAMS = 2,
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
    localparam int DW = AXIS_BYTES * 8
) (
    input  logic                        clk,
    input  logic                        sreset,
    input  logic [NUM_STREAMS-1:0]      enable_mask,
    axis_rr_packet_arbiter_if.slave     axis,
    output logic [IW-1:0]               grant_idx,
    output logic                        busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          last_idx, last_nxt, grant_nxt, winner;
    logic [NUM_STREAMS-1:0] req, tready;
    logic                   found, busy_c, beat_done;
    logic                   o_tvalid, o_tlast;
    logic [DW-1:0]          o_tdata;

    // First requester strictly after the previous winner, wrapping around.
    always_comb begin
        req    = axis.axis_i_tvalid & enable_mask;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_STREAMS; k++) begin
            if (!found && req[IW'((int'(last_idx) + k) % NUM_STREAMS)]) begin
                found  = 1'b1;
                winner = IW'((int'(last_idx) + k) % NUM_STREAMS);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        last_nxt  = last_idx;
        tready    = '0;
        o_tvalid  = 1'b0;
        o_tlast   = 1'b0;
        o_tdata   = '0;
        busy_c    = 1'b0;
        beat_done = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCKED;
                    grant_nxt = winner;
                end
            end
            LOCKED: begin
                busy_c            = 1'b1;
                o_tvalid          = axis.axis_i_tvalid[grant_idx];
                o_tlast           = axis.axis_i_tlast[grant_idx];
                o_tdata           = axis.axis_i_tdata[int'(grant_idx)*DW +: DW];
                tready[grant_idx] = axis.axis_o_tready;
                beat_done         = o_tvalid & axis.axis_o_tready & o_tlast;
                if (beat_done) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IW'(NUM_STREAMS - 1);
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            last_idx  <= last_nxt;
        end
    end

    // Outputs are forced quiet while reset is asserted, even if a packet was in flight.
    assign axis.axis_i_tready = sreset ? '0 : tready;
    assign axis.axis_o_tvalid = !sreset && o_tvalid;
    assign axis.axis_o_tlast  = !sreset && o_tlast;
    assign axis.axis_o_tdata  = sreset ? '0 : o_tdata;
    assign busy               = !sreset && busy_c;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Randomized bench for axis_rr_packet_arbiter (3 sources, 1 byte) with a transaction-level
// reference model, an end-to-end sequence scoreboard and directed literal scenarios.
module tb_axis_rr_packet_arbiter;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         sreset = 1'b1;
    logic [N-1:0] enable_mask = '1;
    logic [1:0]   grant_idx;
    logic         busy;

    always #5 clk = ~clk;

    axis_rr_packet_arbiter_if #(.NUM_STREAMS(N), .AXIS_BYTES(1)) bus ();

    axis_rr_packet_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(N)) dut (
        .clk(clk), .sreset(sreset), .enable_mask(enable_mask),
        .axis(bus), .grant_idx(grant_idx), .busy(busy)
    );

    typedef struct { logic [7:0] d; logic l; int c; } beat_t;
    typedef struct { int g; int c; } gr_t;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    // source configuration (main writes, driver reads)
    int cfg_pkts [N] = '{default: 0};
    int cfg_len  [N] = '{default: 1};
    int cfg_gen = 0;
    int vprob = 100;
    int sink_mode = 0;

    // source state (driver only); data = {src, seq}
    bit         vld   [N] = '{default: 1'b0};
    int         beat  [N] = '{default: 0};
    int         curlen[N] = '{default: 1};
    int         left  [N] = '{default: 0};
    logic [5:0] seq   [N] = '{default: 6'd1};
    int         seen_gen = 0;

    // observations (compare process writes)
    bit    acc [N] = '{default: 1'b0};
    beat_t beats_q[$];
    gr_t   grants_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_len(int i);
        return (cfg_len[i] == 0) ? int'($urandom_range(1, 5)) : cfg_len[i];
    endfunction

    // Source and sink driver: AXIS compliant, valid held until accepted.
    initial begin
        bus.axis_i_tvalid = '0;
        bus.axis_i_tlast  = '0;
        bus.axis_i_tdata  = '0;
        bus.axis_o_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (seen_gen != cfg_gen) begin
                    vld[i] = 1'b0; beat[i] = 0; left[i] = cfg_pkts[i]; curlen[i] = pick_len(i);
                end else if (acc[i]) begin
                    vld[i] = 1'b0;
                    seq[i] = seq[i] + 6'd1;
                    if (beat[i] == curlen[i] - 1) begin
                        beat[i] = 0;
                        if (left[i] > 0) left[i]--;
                        curlen[i] = pick_len(i);
                    end else beat[i]++;
                end
                if (!vld[i] && left[i] != 0 && int'($urandom_range(99)) < vprob) vld[i] = 1'b1;
                bus.axis_i_tvalid[i]       = vld[i];
                bus.axis_i_tlast[i]        = (beat[i] == curlen[i] - 1);
                bus.axis_i_tdata[i*8 +: 8] = {2'(i), seq[i]};
            end
            seen_gen = cfg_gen;
            case (sink_mode)
                0:       bus.axis_o_tready = 1'b1;
                1:       bus.axis_o_tready = (int'($urandom_range(99)) < 70);
                default: bus.axis_o_tready = cyc[0];
            endcase
        end
    end

    // Reference model + per-cycle comparison + scoreboard.
    int         m_owner = -1, m_last = N - 1, m_gidx = 0, sb_cur = -1;
    logic [5:0] sb_exp [N] = '{default: 6'd1};
    bit         prev_busy = 1'b0;

    initial begin
        logic [N-1:0] tv, tl, e_rdy;
        logic         e_v, e_l;
        logic [7:0]   e_d;
        logic [1:0]   o2, s2;
        bit           found;
        int           j;
        forever begin
            @(negedge clk);
            cyc++;
            tv = bus.axis_i_tvalid; tl = bus.axis_i_tlast;
            e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_d = '0;
            o2 = 2'(m_owner);
            if (!sreset && m_owner >= 0) begin
                e_v = tv[o2]; e_l = tl[o2]; e_d = bus.axis_i_tdata[o2*8 +: 8];
                e_rdy[o2] = bus.axis_o_tready;
            end
            chk("o_tvalid", 32'(bus.axis_o_tvalid), 32'(e_v));
            chk("i_tready", 32'(bus.axis_i_tready), 32'(e_rdy));
            chk("busy", 32'(busy), 32'(!sreset && m_owner >= 0));
            if (!sreset) begin
                chk("o_tlast", 32'(bus.axis_o_tlast), 32'(e_l));
                chk("o_tdata", 32'(bus.axis_o_tdata), 32'(e_d));
                chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
            end
            for (int i = 0; i < N; i++) acc[i] = tv[i] & bus.axis_i_tready[i];

            if (!sreset && bus.axis_o_tvalid && bus.axis_o_tready) begin
                beats_q.push_back('{bus.axis_o_tdata, bus.axis_o_tlast, cyc});
                s2 = bus.axis_o_tdata[7:6];
                chk("sb_src_range", 32'(s2 < 2'(N)), 32'd1);
                if (s2 < 2'(N)) begin
                    chk("sb_seq", 32'(bus.axis_o_tdata[5:0]), 32'(sb_exp[s2]));
                    sb_exp[s2] = bus.axis_o_tdata[5:0] + 6'd1;
                end
                if (sb_cur >= 0) chk("sb_interleave", 32'(s2), 32'(sb_cur));
                sb_cur = bus.axis_o_tlast ? -1 : int'(s2);
            end
            if (busy && !prev_busy) grants_q.push_back('{int'(grant_idx), cyc});
            prev_busy = busy;

            if (sreset) begin
                m_owner = -1; m_last = N - 1; m_gidx = 0; sb_cur = -1;
            end else if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (!found && tv[j] && enable_mask[j]) begin
                        found = 1'b1; m_owner = j; m_gidx = j;
                    end
                end
            end else if (tv[o2] && bus.axis_o_tready && tl[o2]) begin
                m_last = m_owner; m_owner = -1;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic restart(int n, int p0, int l0, int p1, int l1, int p2, int l2);
        cfg_pkts = '{p0, p1, p2};
        cfg_len  = '{l0, l1, l2};
        cfg_gen++;
        sreset = 1'b1;
        tick(n);
        sreset = 1'b0;
    endtask

    function automatic int count_src(int from, int s);
        int c = 0;
        for (int k = from; k < beats_q.size(); k++) if (int'(beats_q[k].d[7:6]) == s) c++;
        return c;
    endfunction

    initial begin
        int b0, g0, g1, rel, t;
        int exp_g5 [4] = '{0, 2, 0, 2};

        // 1: reset with all sources valid
        cfg_pkts = '{-1, -1, -1}; cfg_len = '{2, 2, 2}; cfg_gen = 1;
        tick(3);
        sreset = 1'b0;
        @(negedge clk); #1;
        chk("t1_tvalid_after", 32'(bus.axis_o_tvalid), 32'd0);
        chk("t1_tready_after", 32'(bus.axis_i_tready), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_grant_after", 32'(grant_idx), 32'd0);
        tick();

        // 2: single 4-beat packet from src0
        restart(2, 1, 4, 0, 1, 0, 1);
        rel = cyc; b0 = beats_q.size();
        t = 0; while (beats_q.size() < b0 + 4 && t < 50) begin tick(); t++; end
        chk("t2_done", 32'(beats_q.size() >= b0 + 4), 32'd1);
        if (beats_q.size() >= b0 + 4)
            for (int k = 0; k < 4; k++) begin
                chk("t2_data", 32'(beats_q[b0+k].d), 32'(k + 1));
                chk("t2_last", 32'(beats_q[b0+k].l), 32'(k == 3));
                chk("t2_cycle", 32'(beats_q[b0+k].c), 32'(rel + 2 + k));
            end
        chk("t2_grant", 32'(grants_q[$].g), 32'd0);

        // 3: round-robin fairness, continuous 2-beat packets
        restart(2, -1, 2, -1, 2, -1, 2);
        g0 = grants_q.size();
        t = 0; while (grants_q.size() < g0 + 6 && t < 100) begin tick(); t++; end
        chk("t3_done", 32'(grants_q.size() >= g0 + 6), 32'd1);
        if (grants_q.size() >= g0 + 6)
            for (int k = 0; k < 6; k++) begin
                chk("t3_order", 32'(grants_q[g0+k].g), 32'(k % 3));
                if (k > 0) chk("t3_period", 32'(grants_q[g0+k].c - grants_q[g0+k-1].c), 32'd3);
            end

        // 4: backpressure on a src1 packet, src0 valid but masked
        enable_mask = 3'b010; sink_mode = 2;
        restart(2, -1, 4, 1, 4, 0, 1);
        b0 = beats_q.size();
        t = 0; while (count_src(b0, 1) < 4 && t < 80) begin tick(); t++; end
        tick(10);
        chk("t4_src1_beats", 32'(count_src(b0, 1)), 32'd4);
        chk("t4_src0_beats", 32'(count_src(b0, 0)), 32'd0);
        if (beats_q.size() >= b0 + 4) chk("t4_last", 32'(beats_q[b0+3].l), 32'd1);

        // 5: mask 101, then clear bit 0 during a src0 packet
        enable_mask = 3'b101; sink_mode = 0;
        restart(2, -1, 3, -1, 3, -1, 3);
        g0 = grants_q.size();
        t = 0; while (grants_q.size() < g0 + 4 && t < 100) begin tick(); t++; end
        chk("t5_done", 32'(grants_q.size() >= g0 + 4), 32'd1);
        if (grants_q.size() >= g0 + 4)
            for (int k = 0; k < 4; k++) chk("t5_order", 32'(grants_q[g0+k].g), 32'(exp_g5[k]));
        t = 0;
        while (!(grants_q.size() > g0 + 4 && grants_q[$].g == 0 && busy) && t < 100) begin tick(); t++; end
        chk("t5_src0_locked", 32'(busy && grant_idx == 2'd0), 32'd1);
        enable_mask = 3'b100;
        g1 = grants_q.size();
        t = 0; while (grants_q.size() < g1 + 2 && t < 100) begin tick(); t++; end
        chk("t5_done2", 32'(grants_q.size() >= g1 + 2), 32'd1);
        if (grants_q.size() >= g1 + 2) begin
            chk("t5_next_grant", 32'(grants_q[g1].g), 32'd2);
            chk("t5_next_grant2", 32'(grants_q[g1+1].g), 32'd2);
        end

        // 6: reset after beat 2 of a 5-beat src1 packet
        enable_mask = 3'b111;
        restart(2, 0, 1, 1, 5, 0, 1);
        b0 = beats_q.size();
        t = 0; while (count_src(b0, 1) < 2 && t < 50) begin tick(); t++; end
        chk("t6_two_beats", 32'(count_src(b0, 1)), 32'd2);
        restart(2, 1, 2, 1, 2, 0, 1);
        b0 = beats_q.size(); g1 = grants_q.size();
        t = 0; while (grants_q.size() < g1 + 2 && t < 50) begin tick(); t++; end
        tick(5);
        chk("t6_done", 32'(grants_q.size() >= g1 + 2), 32'd1);
        if (grants_q.size() >= g1 + 2) begin
            chk("t6_first_grant", 32'(grants_q[g1].g), 32'd0);
            chk("t6_second_grant", 32'(grants_q[g1+1].g), 32'd1);
        end
        chk("t6_src1_beats", 32'(count_src(b0, 1)), 32'd2);
        chk("t6_src0_beats", 32'(count_src(b0, 0)), 32'd2);

        // random: masks, valid gaps, sink stalls, random lengths, resets mid-packet
        sink_mode = 1;
        b0 = beats_q.size();
        for (int s = 0; s < 12; s++) begin
            enable_mask = N'($urandom);
            vprob = int'($urandom_range(30, 100));
            restart(int'($urandom_range(1, 3)), -1, 0, -1, 0, -1, 0);
            for (int c = 0; c < 200; c++) begin
                if (c % 17 == 16) enable_mask = N'($urandom);
                tick();
            end
        end
        chk("rand_progress", 32'(beats_q.size() > b0 + 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
